// File: rtl/ptl_rx_array.sv
// Array of independent PTL receive channels: guard-filtered pulses pass through a
// per-channel programmable delay line, with sticky guard errors and saturating counters.
module ptl_rx_array #(
  parameter int CH    = 4,
  parameter int DEPTH = 8,
  parameter int GUARD = 2,
  parameter int CNT_W = 16,
  localparam int DW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH-1:0]      din,
  input  logic [CH*DW-1:0]   dly,
  input  logic               cnt_clr,
  input  logic               err_clr,
  output logic [CH-1:0]      dout,
  output logic [CH-1:0]      err,
  output logic [CH*CNT_W-1:0] cnt
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int SW = DEPTH - 1;
  localparam logic [GW-1:0] GLOAD = GW'(GUARD - 1);
  localparam logic [DW-1:0] DMAX  = DW'(DEPTH - 1);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DW-1:0]    dly_in;
    logic [DW-1:0]    dly_q;
    logic [SW-1:0]    sr;
    logic [DEPTH-1:0] line;
    logic [GW-1:0]    guard;
    logic             acc;
    logic             drop;
    logic             flush;
    logic             emit;
    logic             dout_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    // The output flop is the last delay stage, so tap k of {sr, acc} gives latency k+1.
    always_comb begin
      dly_in = dly[c*DW +: DW];
      if (dly_in > DMAX) dly_in = DMAX;
      acc   = din[c] && (guard == '0);
      drop  = din[c] && (guard != '0);
      flush = (dly_in != dly_q);
      line  = {sr, acc};
      emit  = flush ? (acc && (dly_in == '0)) : line[dly_in];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q  <= '0;
        sr     <= '0;
        guard  <= '0;
        dout_q <= 1'b0;
        err_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        dly_q <= dly_in;
        // A delay change discards everything in flight but keeps this edge's pulse.
        sr    <= flush ? SW'(acc) : line[SW-1:0];
        if (acc)
          guard <= GLOAD;
        else if (guard != '0)
          guard <= guard - GW'(1);
        dout_q <= emit;
        err_q  <= (err_q && !err_clr) || drop;
        if (cnt_clr)
          cnt_q <= '0;
        else if (emit && (cnt_q != '1))
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign dout[c]                 = dout_q;
    assign err[c]                  = err_q;
    assign cnt[c*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_ptl_rx_array.sv
// Bench for ptl_rx_array: directed scenarios plus random traffic, checked every cycle
// by a monitor against a time-stamped reference model of accepted pulses.
module tb_ptl_rx_array;
  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int GUARD = 2;
  localparam int CNT_W = 4;
  localparam int DW    = $clog2(DEPTH);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cnt_clr = 1'b0;
  logic                err_clr = 1'b0;
  logic [CH-1:0]       din = '0;
  logic [CH*DW-1:0]    dly = '0;
  logic [CH-1:0]       dout;
  logic [CH-1:0]       err;
  logic [CH*CNT_W-1:0] cnt;

  ptl_rx_array #(.CH(CH), .DEPTH(DEPTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dly(dly), .cnt_clr(cnt_clr),
    .err_clr(err_clr), .dout(dout), .err(err), .cnt(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: expected emission cycles per channel plus event logs by cycle.
  int            exp_q [CH][$];
  int            last_acc [CH];
  int            dly_m [CH];
  int            cnt_m [CH];
  logic          err_m [CH];
  logic [CH-1:0] drop_at [int];
  bit            cclr_at [int];
  bit            eclr_at [int];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      exp_q[c].delete();
      last_acc[c] = -1000;
      dly_m[c]    = 0;
      cnt_m[c]    = 0;
      err_m[c]    = 1'b0;
    end
    drop_at.delete();
    cclr_at.delete();
    eclr_at.delete();
  endtask

  // Called with the inputs of cycle cyc in place, before the edge that samples them.
  task automatic model_apply();
    logic [CH-1:0] drops;
    int dn;
    drops = '0;
    for (int c = 0; c < CH; c++) begin
      dn = int'(dly[c*DW +: DW]);
      if (dn > DEPTH - 1) dn = DEPTH - 1;
      if (dn != dly_m[c]) begin
        while (exp_q[c].size() > 0 && exp_q[c][$] > cyc) void'(exp_q[c].pop_back());
        dly_m[c] = dn;
      end
      if (din[c]) begin
        if (cyc - last_acc[c] >= GUARD) begin
          last_acc[c] = cyc;
          exp_q[c].push_back(cyc + dn + 1);
        end else begin
          drops[c] = 1'b1;
        end
      end
    end
    if (drops != '0) drop_at[cyc] = drops;
    if (cnt_clr) cclr_at[cyc] = 1'b1;
    if (err_clr) eclr_at[cyc] = 1'b1;
  endtask

  task automatic step(input logic [CH-1:0] d, input logic cc, input logic ec);
    din = d;
    cnt_clr = cc;
    err_clr = ec;
    model_apply();
    @(posedge clk);
    cyc++;
    #1;
    din = '0;
    cnt_clr = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  task automatic set_dly(input int c, input logic [DW-1:0] v);
    dly[c*DW +: DW] = v;
  endtask

  task automatic mid_reset(input int n);
    #1 rst_n = 1'b0;
    #1;
    chk("reset dout", int'(dout), 0);
    chk("reset err", int'(err), 0);
    chk("reset cnt", int'(cnt), 0);
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every cycle, every channel, outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        bit e;
        e = (exp_q[c].size() > 0) && (exp_q[c][0] == cyc);
        if (e && cnt_m[c] < CMAX) cnt_m[c]++;
        if (cclr_at.exists(cyc - 1)) cnt_m[c] = 0;
        if (eclr_at.exists(cyc - 1)) err_m[c] = 1'b0;
        if (drop_at.exists(cyc - 1) && drop_at[cyc - 1][c]) err_m[c] = 1'b1;
        chk($sformatf("dout[%0d]", c), int'(dout[c]), int'(e));
        chk($sformatf("cnt[%0d]", c), int'(cnt[c*CNT_W +: CNT_W]), cnt_m[c]);
        chk($sformatf("err[%0d]", c), int'(err[c]), int'(err_m[c]));
        while (exp_q[c].size() > 0 && exp_q[c][0] <= cyc) void'(exp_q[c].pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #2;
    chk("reset dout", int'(dout), 0);
    chk("reset cnt", int'(cnt), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed delays 0/3/7, one pulse on three channels.
    set_dly(0, 3'd0); set_dly(1, 3'd3); set_dly(2, 3'd7); set_dly(3, 3'd0);
    idle(10);
    step(4'b0111, 1'b0, 1'b0);
    idle(10);
    chk("A cnt0", int'(cnt[0*CNT_W +: CNT_W]), 1);
    chk("A cnt1", int'(cnt[1*CNT_W +: CNT_W]), 1);
    chk("A cnt2", int'(cnt[2*CNT_W +: CNT_W]), 1);
    chk("A err", int'(err), 0);

    // Guard: three consecutive pulses, the middle one is dropped.
    step('0, 1'b1, 1'b0);
    idle(3);
    repeat (3) step(4'b0001, 1'b0, 1'b0);
    idle(4);
    chk("B err0", int'(err[0]), 1);
    chk("B cnt0", int'(cnt[0*CNT_W +: CNT_W]), 2);
    step('0, 1'b0, 1'b1);
    chk("B err0 cleared", int'(err[0]), 0);

    // Delay change discards an in-flight pulse.
    step('0, 1'b1, 1'b0);
    set_dly(1, 3'd5);
    idle(3);
    step(4'b0010, 1'b0, 1'b0);
    idle(1);
    set_dly(1, 3'd2);
    idle(8);
    chk("C cnt1 flushed", int'(cnt[1*CNT_W +: CNT_W]), 0);
    step(4'b0010, 1'b0, 1'b0);
    idle(5);
    chk("C cnt1 new", int'(cnt[1*CNT_W +: CNT_W]), 1);

    // Counter saturation, then clear coincident with an emission.
    for (int i = 0; i < 20; i++) begin
      step(4'b1000, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
    end
    chk("D cnt3 sat", int'(cnt[3*CNT_W +: CNT_W]), CMAX);
    step(4'b1000, 1'b1, 1'b0);
    chk("D dout3", int'(dout[3]), 1);
    chk("D cnt3 clr wins", int'(cnt[3*CNT_W +: CNT_W]), 0);
    idle(2);

    // Reset with a pulse in flight on a long delay.
    set_dly(0, 3'd7);
    idle(3);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    idle(1);
    mid_reset(2);
    idle(12);

    // Random traffic with mostly fixed delays.
    for (int c = 0; c < CH; c++) set_dly(c, DW'($urandom_range(0, DEPTH - 1)));
    for (int i = 0; i < 1500; i++) begin
      logic [CH-1:0] d;
      for (int c = 0; c < CH; c++) d[c] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0)
        set_dly($urandom_range(0, CH - 1), DW'($urandom_range(0, DEPTH - 1)));
      step(d, $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
    end
    idle(12);
    for (int c = 0; c < CH; c++)
      chk($sformatf("pending[%0d]", c), exp_q[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptl_rx_array.md
PTL_RX_ARRAY -- requirements
Module: ptl_rx_array

Interface
REQ-001 Parameter CH, default 4, number of independent PTL receive channels (1..32).
REQ-002 Parameter DEPTH, default 8, maximum delay-line length in clk cycles (2..64).
REQ-003 Parameter GUARD, default 2, minimum accepted pulse spacing in clk cycles (>=1; 1 disables guard check).
REQ-004 Parameter CNT_W, default 16, per-channel pulse-counter width (4..32).
REQ-005 Derived DW = clog2(DEPTH), width of one channel's delay field.
REQ-006 clk  input  1  single clock for all state.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 din  input  CH  incoming pulse per channel; one-cycle high = one pulse.
REQ-009 dly  input  CH*DW  per-channel delay select; field c at bits [c*DW +: DW]; value d gives latency d+1.
REQ-010 cnt_clr  input  1  synchronous clear of all pulse counters.
REQ-011 err_clr  input  1  synchronous clear of all sticky error flags.
REQ-012 dout  output  CH  delayed pulse per channel, registered.
REQ-013 err  output  CH  sticky guard-violation flag per channel.
REQ-014 cnt  output  CH*CNT_W  forwarded-pulse count per channel; field c at bits [c*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL own a DEPTH-stage shift register, a DW-bit registered delay copy, a guard down-counter, a sticky err bit and a CNT_W-bit counter; channels SHALL not interact.
REQ-016 An accepted pulse on din[c] in cycle t SHALL appear on dout[c] for exactly one cycle at t+d+1, d = registered dly field.
REQ-017 dly field values >= DEPTH SHALL be clamped to DEPTH-1.
REQ-018 dly SHALL be registered every cycle; when the registered value of channel c changes, that channel's shift register SHALL be cleared in the same edge; in-flight pulses are discarded, not emitted, not counted.
REQ-019 Guard: after an accepted pulse the guard counter loads GUARD-1 and decrements to 0 once per cycle; a din pulse while counter != 0 SHALL be dropped and SHALL set err[c].
REQ-020 A dropped pulse SHALL NOT reload the guard counter.
REQ-021 GUARD=1: every din pulse accepted, err never set.
REQ-022 err[c] SHALL stay high until err_clr; err_clr and a new violation in the same cycle: err[c] ends high (set wins).
REQ-023 cnt[c] SHALL increment by 1 in the cycle dout[c] is high, saturating at 2^CNT_W-1 (no wrap).
REQ-024 cnt_clr and an emission in the same cycle: counter ends 0 (clear wins).
REQ-025 Pulses accepted back-to-back (spacing >= GUARD) SHALL all be emitted in order with identical spacing; no merging.
REQ-026 dout, err, cnt SHALL be driven directly from flops (no combinational path from inputs).

Reset
REQ-027 rst_n low SHALL asynchronously clear all shift registers, guard counters, dout, err, cnt, and load registered dly to 0.
REQ-028 Reset deasserted mid-flight: pulses present before reset SHALL never appear on dout.
REQ-029 First din sampled on the first rising clk edge after rst_n high; the dly 0->value transition at that edge SHALL flush per REQ-018 only if it precedes pulse capture (pulses arriving on that same edge are accepted with the new delay).

Verification
REQ-030 CH=4, dly ch0=0, ch1=3, ch2=7; single pulse on din[2:0] at cycle 10 -> dout[0] at 11, dout[1] at 14, dout[2] at 18; cnt[2:0]=1 each, err=0.
REQ-031 GUARD=2, ch0 pulses at cycles 10,11,12 -> pulses at 10 and 12 emitted (11,13 with d=0), cycle 11 dropped, err[0]=1, cnt[0]=2; err_clr at 20 -> err[0]=0.
REQ-032 ch1 dly=5, pulse at 10, dly changed to 2 at 12 -> no dout[1] at 16, cnt[1]=0; new pulse at 20 -> dout[1] at 23.
REQ-033 CNT_W=4, GUARD=1, 20 consecutive pulses ch3 -> cnt[3] reaches 15 and holds; cnt_clr coincident with an emission -> cnt[3]=0.
REQ-034 Pulse in ch0 with dly=7 at 10, rst_n low at 13 (between edges), high at 15 -> dout, err, cnt all 0 immediately at 13, no dout[0] at 18.
REQ-035 Random din on all channels, GUARD=3, fixed dly: scoreboard confirms per-channel order, latency d+1, drop/err rule, cnt = emitted count.
